char_uart_rx: RTL and testbench
===============================

Name: char_uart_rx

Overview:
- Serial-to-character front end for the Smart-Room keyword detectors.
- Receives an asynchronous 8N1 serial line: idle high, 1 start bit, 8 data bits LSB first, 1 stop bit.
- Presents each received ASCII byte on a parallel bus with a one-cycle valid strobe.
- Sits directly upstream of the "BAZ" sequence detector and feeds its character input.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be even and >= 4.
- DATA_BITS, 8: data bits per frame. Fixed at 8 for the detector path.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- rx_i  input  1  raw serial line, asynchronous to clk, idle = 1.
- char_o  output  8  last correctly received character; held stable between frames.
- char_valid_o  output  1  one-cycle pulse when char_o is updated with a new good frame.
- frame_err_o  output  1  one-cycle pulse when a frame's stop bit samples 0.
- busy_o  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values: char_o = 8'h00, char_valid_o = 0, frame_err_o = 0, busy_o = 0, state = IDLE. Synchronizer flops reset to 1 (line idle).
- Input sync: rx_i passes through 2 flops (rx_s). All logic uses rx_s only. This adds 2 cycles of latency.
- Counters: bit-time counter cnt, width clog2(CLKS_PER_BIT); data index idx, 0..7.
- IDLE: when rx_s == 0, go to START with cnt = 0.
- START: count to CLKS_PER_BIT/2 - 1 (mid start bit), then re-sample rx_s.
  - rx_s == 1: glitch; return to IDLE, no outputs.
  - rx_s == 0: go to DATA with cnt = 0, idx = 0.
- DATA: on each cnt == CLKS_PER_BIT - 1, shift rx_s into shift register bit idx (LSB first) and reset cnt. After idx 7 is sampled, go to STOP.
- STOP: on cnt == CLKS_PER_BIT - 1, sample rx_s.
  - rx_s == 1: next cycle char_o <= shift register, char_valid_o = 1 for exactly 1 cycle; go to IDLE.
  - rx_s == 0: frame_err_o = 1 for 1 cycle, char_o unchanged, no valid; go to BREAK.
- BREAK: wait until rx_s == 1 (line released), then go to IDLE. A held-low line therefore produces exactly one frame_err_o, not repeated frames.
- Latency: char_valid_o rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx_i falling edge (+-1 for sync phase). With default parameters this is 155 +-1 cycles.
- Back-to-back frames: a start bit immediately after the stop-bit midpoint must be caught. IDLE is re-entered before the next falling edge can reach rx_s.
- char_valid_o and frame_err_o are never high together.
- rst asserted mid-frame: abort immediately, partial data discarded, no pulse emitted.
- After rst is deasserted with rx_i low: wait for high before accepting a frame. The synchronizer reset value of 1 plus the IDLE edge rule guarantees this (IDLE requires rx_s to go 1 -> 0; track the previous rx_s).

Decomposition:
- Shared package char_pkg:
  - UART state enum: IDLE, START, DATA, STOP, BREAK.
  - ASCII constants: CH_B = 8'h42, CH_A = 8'h41, CH_Z = 8'h5A.
  - Default CLKS_PER_BIT.
- One natural sub-module: sync_2ff, a reusable 2-flop synchronizer with reset value parameter RST_VAL.

Test Plan:
- Reset with rx_i = 1, then release -> all outputs 0, busy_o = 0, no pulses for 500 cycles.
- Send 0x42 ('B') at CLKS_PER_BIT = 16 -> char_valid_o one pulse about 155 cycles after the falling edge, char_o = 8'h42, frame_err_o never high.
- Send "B","A","Z" back-to-back with zero idle gap -> three valid pulses, char_o sequence 0x42, 0x41, 0x5A, pulses spaced 160 cycles apart.
- 5-cycle low glitch on idle line -> no valid, no frame_err; busy_o returns to 0 within 10 cycles.
- Frame 0x4D with stop bit forced 0, line held low 400 cycles, then high -> exactly one frame_err_o pulse; char_o keeps its previous value; the next good frame 0x41 is received correctly.
- Assert rst during data bit 4 of a frame -> outputs clear at once, no valid pulse; a subsequent full frame 0x5A is received correctly.

Source files
------------

// File: rtl/char_pkg.sv
// Shared definitions for the Smart-Room character path: UART states, ASCII
// keyword characters and the default bit timing.
package char_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned STATE_W          = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_START = 3'd1;
   localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
   localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
   localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

   localparam logic [7:0] CH_B = 8'h42;
   localparam logic [7:0] CH_A = 8'h41;
   localparam logic [7:0] CH_Z = 8'h5A;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line reads as idle straight out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/char_uart_rx.sv
// 8N1 serial receiver feeding the keyword detectors: one character per good
// frame with a single-cycle valid strobe, single-cycle frame-error strobe.
module char_uart_rx
   import char_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] char_o,
   output logic       char_valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 rx_prev;
   logic [STATE_W-1:0]   state,     state_nxt;
   logic [CNT_W-1:0]     cnt,       cnt_nxt;
   logic [IDX_W-1:0]     idx,       idx_nxt;
   logic [DATA_BITS-1:0] sh,        sh_nxt;
   logic [7:0]           char_nxt;
   logic                 valid_nxt;
   logic                 ferr_nxt;
   logic                 busy_nxt;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_i),
      .q   (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_prev      <= 1'b1;
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         sh           <= '0;
         char_o       <= 8'h00;
         char_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         rx_prev      <= rx_s;
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         sh           <= sh_nxt;
         char_o       <= char_nxt;
         char_valid_o <= valid_nxt;
         frame_err_o  <= ferr_nxt;
         busy_o       <= busy_nxt;
      end
   end

   // A frame only starts on a 1->0 edge, so a line held low out of reset
   // or after a break is ignored until it returns high.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      sh_nxt    = sh;
      char_nxt  = char_o;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (rx_prev && !rx_s) begin
               state_nxt = ST_START;
               cnt_nxt   = '0;
            end
         end
         ST_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DATA;
                  idx_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt     = '0;
               sh_nxt[idx] = rx_s;
               if (idx == IDX_LAST) begin
                  state_nxt = ST_STOP;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  char_nxt  = 8'(sh);
                  valid_nxt = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = ST_BREAK;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_char_uart_rx.sv
// Directed bench for char_uart_rx: a table of single frames plus hand-written
// back-to-back, glitch, break and mid-frame reset sequences.
module tb_char_uart_rx;
   import char_pkg::*;

   localparam int CPB = 16;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [7:0] char_o;
   logic       char_valid_o;
   logic       frame_err_o;
   logic       busy_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int vcnt     = 0;
   int fcnt     = 0;
   int overlap  = 0;
   int busy_cnt = 0;
   int last_v   = 0;
   logic [7:0] chq[$];
   int         vq[$];

   char_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx_i),
      .char_o       (char_o),
      .char_valid_o (char_valid_o),
      .frame_err_o  (frame_err_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (char_valid_o) begin
            vcnt++;
            last_v = cyc;
            chq.push_back(char_o);
            vq.push_back(cyc);
         end
         if (frame_err_o) fcnt++;
         if (char_valid_o && frame_err_o) overlap++;
         if (busy_o) busy_cnt++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and hold for n edges.
   task automatic drive(input logic v, input int n);
      rx_i = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stp, output int fall);
      fall = cyc;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(d[i], CPB);
      drive(stp, CPB);
      rx_i = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_char;
      int         exp_valid;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int fall;
      int v0, f0;

      vecs[0] = '{8'h42, 1'b1, 8'h42, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
      vecs[3] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
      vecs[4] = '{8'h3C, 1'b0, 8'hA5, 0, 1};

      // reset with idle line
      rst  = 1'b1;
      rx_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_char", int'(char_o), 0);
      chk("rst_valid", int'(char_valid_o), 0);
      chk("rst_ferr", int'(frame_err_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      rst = 1'b0;
      drive(1'b1, 500);
      chk("quiet_valid", vcnt, 0);
      chk("quiet_ferr", fcnt, 0);
      chk("quiet_busy", busy_cnt, 0);

      // single frames from the table
      foreach (vecs[k]) begin
         v0 = vcnt;
         f0 = fcnt;
         send_frame(vecs[k].data, vecs[k].stop, fall);
         drive(1'b1, 40);
         chk($sformatf("vec%0d_valid", k), vcnt - v0, vecs[k].exp_valid);
         chk($sformatf("vec%0d_ferr", k), fcnt - f0, vecs[k].exp_ferr);
         chk($sformatf("vec%0d_char", k), int'(char_o), int'(vecs[k].exp_char));
         chk($sformatf("vec%0d_busy", k), int'(busy_o), 0);
         if (vecs[k].exp_valid == 1)
            chk($sformatf("vec%0d_latency", k), last_v - fall, LAT);
      end

      // B, A, Z with no idle gap between frames
      chq.delete();
      vq.delete();
      send_frame(CH_B, 1'b1, fall);
      send_frame(CH_A, 1'b1, fall);
      send_frame(CH_Z, 1'b1, fall);
      drive(1'b1, 40);
      chk("baz_count", chq.size(), 3);
      if (chq.size() == 3 && vq.size() == 3) begin
         chk("baz_c0", int'(chq[0]), int'(CH_B));
         chk("baz_c1", int'(chq[1]), int'(CH_A));
         chk("baz_c2", int'(chq[2]), int'(CH_Z));
         chk("baz_gap01", vq[1] - vq[0], 10 * CPB);
         chk("baz_gap12", vq[2] - vq[1], 10 * CPB);
      end

      // short low glitch on the idle line
      v0 = vcnt;
      f0 = fcnt;
      drive(1'b0, 5);
      drive(1'b1, 10);
      chk("glitch_busy", int'(busy_o), 0);
      drive(1'b1, 200);
      chk("glitch_valid", vcnt - v0, 0);
      chk("glitch_ferr", fcnt - f0, 0);

      // bad stop bit, then line held low as a break
      v0 = vcnt;
      f0 = fcnt;
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(v0[0] ^ v0[0] ^ (8'h4D >> i) & 1'b1, CPB);
      drive(1'b0, 400);
      drive(1'b1, 20);
      chk("break_ferr", fcnt - f0, 1);
      chk("break_valid", vcnt - v0, 0);
      chk("break_char", int'(char_o), int'(CH_Z));
      v0 = vcnt;
      send_frame(CH_A, 1'b1, fall);
      drive(1'b1, 40);
      chk("after_break_valid", vcnt - v0, 1);
      chk("after_break_char", int'(char_o), int'(CH_A));

      // reset during data bit 4
      v0 = vcnt;
      f0 = fcnt;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive((8'h5A >> i) & 1'b1, CPB);
      drive(1'b1, CPB / 2);
      rst = 1'b1;
      #1;
      chk("midrst_char", int'(char_o), 0);
      chk("midrst_valid", int'(char_valid_o), 0);
      chk("midrst_busy", int'(busy_o), 0);
      chk("midrst_ferr", int'(frame_err_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 200);
      chk("midrst_no_pulse", vcnt - v0, 0);
      chk("midrst_no_ferr", fcnt - f0, 0);
      send_frame(CH_Z, 1'b1, fall);
      drive(1'b1, 40);
      chk("midrst_next_valid", vcnt - v0, 1);
      chk("midrst_next_char", int'(char_o), int'(CH_Z));
      chk("midrst_next_latency", last_v - fall, LAT);

      chk("valid_ferr_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
